serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and difference width in bits (legal range 2..32).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port START, input, 1 bit: request to begin a subtraction; sampled on the rising edge.
REQ-005 SHALL have port A, input, WIDTH bits: minuend; captured when START is accepted.
REQ-006 SHALL have port B, input, WIDTH bits: subtrahend; captured when START is accepted.
REQ-007 SHALL have port BIN, input, 1 bit: borrow-in; captured when START is accepted.
REQ-008 SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port DONE, output, 1 bit: a one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port D, output, WIDTH bits: difference, registered.
REQ-011 SHALL have port BOUT, output, 1 bit: final borrow-out, registered.

Function
REQ-012 SHALL compute {BOUT,D} = A - B - BIN, with BOUT=1 exactly when A < B + BIN (unsigned).
REQ-013 SHALL compute bit-serially, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
REQ-014 SHALL use the cell equations diff = a^b^br and br_next = (~a&b) | (~(a^b)&br).
REQ-015 SHALL implement FSM states IDLE, SHIFT and FIN; reset state is IDLE.
REQ-016 IDLE, START=1: SHALL load A and B into internal shift registers, load BIN into the borrow flip-flop, clear the bit counter, and go to SHIFT.
REQ-017 IDLE, START=0: SHALL stay in IDLE.
REQ-018 SHIFT: each edge SHALL shift the operands right by 1, shift the diff bit into the MSB of the working result register, update the borrow flip-flop, and increment the counter.
REQ-019 SHIFT: SHALL go to FIN on the edge that processes bit WIDTH-1.
REQ-020 On the SHIFT-to-FIN edge, SHALL copy the working result to D and the final borrow to BOUT.
REQ-021 FIN: SHALL return to IDLE on the next edge, or act as IDLE (REQ-016) if START=1 in that cycle.
REQ-022 BUSY SHALL be 1 in SHIFT and 0 in IDLE and FIN.
REQ-023 DONE SHALL be 1 only in FIN.
REQ-024 Latency: DONE SHALL be high in the cycle following the WIDTH-th rising edge after the edge that accepted START.
REQ-025 Latency: DONE SHALL stay high for exactly 1 cycle.
REQ-026 D and BOUT SHALL hold their value from the FIN transition until the next completion; they do not change during SHIFT.
REQ-027 START during SHIFT SHALL be ignored, with no effect on state, operands or outputs.
REQ-028 A, B and BIN changing after acceptance SHALL not affect the result in progress.
REQ-029 Back-to-back operation: START held high continuously SHALL give one result every WIDTH+1 cycles.

Reset
REQ-030 While RST_N=0, regardless of CLK: state=IDLE, BUSY=0, DONE=0, D=0, BOUT=0, and internal shift registers, counter and borrow cleared.
REQ-031 Reset asserted mid-operation SHALL abort the operation; no DONE is produced for it.
REQ-032 After RST_N rises, the first START SHALL be accepted on the first rising edge at which it is seen high.

Verification (WIDTH=8)
REQ-033 A=0x5A, B=0x23, BIN=0, START for 1 cycle -> BUSY for 8 cycles, then a DONE pulse; D=0x37, BOUT=0.
REQ-034 A=0x00, B=0x01, BIN=0 -> D=0xFF, BOUT=1; A=0x10, B=0x10, BIN=1 -> D=0xFF, BOUT=1; A=0xFF, B=0xFF, BIN=0 -> D=0x00, BOUT=0.
REQ-035 START pulsed again at SHIFT cycle 3 with A=0x00, B=0xFF -> ignored; first result is unchanged and exactly one DONE pulse occurs.
REQ-036 Drive RST_N low at SHIFT cycle 4, between edges -> BUSY, D and BOUT go to 0 immediately; no DONE follows; a new START after release gives the correct result.
REQ-037 START held high with operand pairs (0x80,0x01) then (0x03,0x05) -> DONE pulses 9 cycles apart; D=0x7F with BOUT=0, then D=0xFE with BOUT=1.
REQ-038 Random regression: 1000 random A, B, BIN -> every {BOUT,D} matches the reference model A-B-BIN mod 2^9.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - BIN using one full-subtractor cell, LSB first, one bit per clock.
// Result is valid WIDTH+1 cycles after START is accepted. START is ignored while BUSY is high.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             diff;
  logic             borrow_nxt;
  logic             last_bit;
  logic             load;

  assign diff       = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE, FIN: begin
        DONE = (state == FIN);
        if (START) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (last_bit) begin
          state_nxt = FIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right so the cell always sees bit 0; the result fills from the MSB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      D      <= '0;
      BOUT   <= 1'b0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= B;
      borrow <= BIN;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {diff, res_sr[WIDTH-1:1]};
      borrow <= borrow_nxt;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        D    <= {diff, res_sr[WIDTH-1:1]};
        BOUT <= borrow_nxt;
      end
    end
  end

endmodule
